seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for an N-digit seven-segment display.
//   Holds a packed BCD display word and selects one digit at a time at a
//   programmable refresh rate. Drives the bcd/blank inputs of the shared
//   BCD-to-segment decoder plus the per-digit enables.
//   New values are double-buffered and applied only at frame boundaries,
//   so the display never tears.
// PARAMETERS
//   NUM_DIGITS   4      digits scanned, 1..8
//   DIV_WIDTH    16     prescaler counter width
//   REFRESH_DIV  50000  clk cycles per digit slot, 2..2**DIV_WIDTH-1
//   DEAD_CYCLES  2      cycles at the start of each slot with all digit_en inactive; < REFRESH_DIV
// PORTS
//   clk           in   1             single clock; all logic on posedge
//   rst           in   1             synchronous, active-high reset
//   load          in   1             strobe: capture value_in into the pending buffer
//   value_in      in   4*NUM_DIGITS  packed BCD; digit 0 = bits [3:0] (least significant)
//   blank_in      in   1             global blank request
//   digit_act_low in   1             1: digit_en asserted low (common-anode drivers)
//   bcd           out  4             BCD nibble of the active digit, to the decoder
//   blank         out  1             blank request, to the decoder
//   digit_en      out  NUM_DIGITS    one-hot digit select, polarity per digit_act_low
//   digit_idx     out  3             index of the current slot
//   frame_start   out  1             1-cycle pulse when the scan wraps to digit 0
//   load_ack      out  1             1-cycle pulse when the pending value is applied to the display
// BEHAVIOUR
//   - Reset: prescaler=0, digit_idx=0, display=0, pending_valid=0, bcd=0, blank=1,
//     digit_en all inactive (depends on digit_act_low), frame_start=0, load_ack=0.
//   - Prescaler counts 0..REFRESH_DIV-1 and wraps. tick = (prescaler==REFRESH_DIV-1).
//   - On tick, digit_idx advances; NUM_DIGITS-1 wraps to 0 (frame boundary).
//     frame_start is high in the cycle after the wrap edge.
//   - Load: pending <= value_in, pending_valid <= 1. A later load before the
//     boundary overwrites pending (last write wins).
//   - Boundary with pending_valid: display <= pending, pending_valid <= 0, load_ack pulses.
//   - Load coinciding with the boundary tick: value_in goes straight to display,
//     pending_valid <= 0, load_ack pulses. The older pending value is dropped.
//   - All outputs are registered from next-state. bcd/blank reflect the new
//     digit_idx on the same edge that digit_idx changes.
//   - digit_en: one-hot(digit_idx) while prescaler >= DEAD_CYCLES, otherwise all inactive.
//     Inverted when digit_act_low=1. Never more than one digit is active.
//   - blank = blank_in (registered, 1-cycle latency) OR the leading-zero rule below.
//   - digit_act_low change takes effect on the next edge; no other state changes.
//   - rst asserted mid-frame returns all state to reset values on that edge.
//     A pending value is lost.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: a digit i>0 is blanked when display digits
//     i..NUM_DIGITS-1 are all 0. Digit 0 is never blanked by this rule
//     (value 0 shows "0").
//   Not defined: only blank_in blanks. Zeros are shown on every digit.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1)
//   1. Reset, idle -> digit_idx steps 0,1,2,3,0 every 4 clk; frame_start pulses
//      once per 16 clk; bcd=0.
//   2. load value_in=16'h1234 mid-frame -> display unchanged until wrap, then
//      load_ack; slot 0 bcd=4, slot 3 bcd=1.
//   3. Two loads (16'h1111 then 16'h2222) within one frame -> only 2222
//      displayed; one load_ack.
//   4. Load 16'h0005 on the boundary tick cycle -> displayed from digit 0 of
//      that frame. With LEADING_ZERO_BLANK_EN, blank=1 on digits 1..3 and 0 on
//      digit 0; without it, blank=0 throughout.
//   5. digit_act_low=1 -> digit_en=4'b1111 in the dead cycle and 4'b1110 for
//      slot 0; blank_in=1 -> blank=1 on the next edge.
//   6. rst pulse in slot 2 with a pending load -> next cycle at reset values;
//      no load_ack ever occurs for that load.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an N-digit
// seven-segment display driven through a shared BCD-to-segment decoder.
//
// The display word is double-buffered: loads land in a pending buffer and
// are copied to the visible word only at the frame boundary (scan wrap to
// digit 0), so a frame never shows a mix of old and new digits.
//
// Each digit slot lasts REFRESH_DIV clocks. The first DEAD_CYCLES clocks of
// every slot keep all digit enables inactive to avoid ghosting while the
// segment lines settle on the new digit's value.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   : digit i>0 is blanked while display digits i..NUM_DIGITS-1
//               are all zero (digit 0 always shows, so a value of 0 reads "0").
//   undefined : only blank_in_i blanks; zeros are shown on every digit.
//
// All outputs are registers loaded from next-state, so bcd_o/blank_o/
// digit_en_o change on the same edge as digit_idx_o.

module seg_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int DIV_WIDTH   = 16,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    load_i,
   input  logic [4*NUM_DIGITS-1:0] value_in_i,
   input  logic                    blank_in_i,
   input  logic                    digit_act_low_i,
   output logic [3:0]              bcd_o,
   output logic                    blank_o,
   output logic [NUM_DIGITS-1:0]   digit_en_o,
   output logic [2:0]              digit_idx_o,
   output logic                    frame_start_o,
   output logic                    load_ack_o
);

   localparam int                   VW         = 4 * NUM_DIGITS;
   localparam logic [DIV_WIDTH-1:0] PRESC_LAST = DIV_WIDTH'(REFRESH_DIV - 1);
   localparam logic [DIV_WIDTH-1:0] DEAD_CNT   = DIV_WIDTH'(DEAD_CYCLES);
   localparam logic [2:0]           LAST_IDX   = 3'(NUM_DIGITS - 1);

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------

   // Pick the BCD nibble of digit idx out of the packed display word.
   function automatic logic [3:0] sel_nibble(input logic [VW-1:0] word,
                                             input logic [2:0]    idx);
      logic [3:0] nib;
      nib = 4'h0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == 3'(i)) begin
            nib = word[i*4 +: 4];
         end else begin
            nib = nib;
         end
      end
      return nib;
   endfunction

   // One-hot active-high enable for digit idx.
   function automatic logic [NUM_DIGITS-1:0] onehot_en(input logic [2:0] idx);
      logic [NUM_DIGITS-1:0] en;
      en = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         en[i] = (idx == 3'(i));
      end
      return en;
   endfunction

`ifdef LEADING_ZERO_BLANK_EN
   // True when digit idx (>0) and every more significant digit are zero.
   function automatic logic lz_blank(input logic [VW-1:0] word,
                                     input logic [2:0]    idx);
      logic all_zero;
      logic res;
      all_zero = 1'b1;
      res      = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         all_zero = all_zero & (word[i*4 +: 4] == 4'h0);
         if (idx == 3'(i)) begin
            res = all_zero;
         end else begin
            res = res;
         end
      end
      return res;
   endfunction
`endif

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [DIV_WIDTH-1:0]  presc_q,       presc_d;
   logic [2:0]            idx_q,         idx_d;
   logic [VW-1:0]         display_q,     display_d;
   logic [VW-1:0]         pending_q,     pending_d;
   logic                  pend_valid_q,  pend_valid_d;
   logic [3:0]            bcd_q,         bcd_d;
   logic                  blank_q,       blank_d;
   logic [NUM_DIGITS-1:0] digit_en_q,    digit_en_d;
   logic                  frame_start_q, frame_start_d;
   logic                  load_ack_q,    load_ack_d;

   logic                  tick_s;
   logic                  wrap_s;
   logic                  lz_s;
   logic [NUM_DIGITS-1:0] en_raw_s;

   // Prescaler and slot index: advance one slot every REFRESH_DIV clocks.
   always_comb begin
      tick_s  = (presc_q == PRESC_LAST);
      wrap_s  = tick_s && (idx_q == LAST_IDX);
      presc_d = presc_q + DIV_WIDTH'(1);
      idx_d   = idx_q;
      if (tick_s) begin
         presc_d = '0;
         if (idx_q == LAST_IDX) begin
            idx_d = 3'd0;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end else begin
         presc_d = presc_q + DIV_WIDTH'(1);
         idx_d   = idx_q;
      end
   end

   // Double buffer: loads go to pending, pending moves to display at the
   // frame boundary; a load on the boundary itself goes straight through
   // and supersedes any older pending value.
   always_comb begin
      display_d    = display_q;
      pending_d    = pending_q;
      pend_valid_d = pend_valid_q;
      load_ack_d   = 1'b0;
      if (wrap_s && load_i) begin
         display_d    = value_in_i;
         pend_valid_d = 1'b0;
         load_ack_d   = 1'b1;
      end else if (wrap_s && pend_valid_q) begin
         display_d    = pending_q;
         pend_valid_d = 1'b0;
         load_ack_d   = 1'b1;
      end else if (load_i) begin
         pending_d    = value_in_i;
         pend_valid_d = 1'b1;
      end else begin
         display_d    = display_q;
         pend_valid_d = pend_valid_q;
      end
   end

   // Decoder-facing outputs, computed from the next slot and next display.
   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      lz_s = lz_blank(display_d, idx_d);
`else
      lz_s = 1'b0;
`endif
      bcd_d         = sel_nibble(display_d, idx_d);
      blank_d       = blank_in_i | lz_s;
      frame_start_d = wrap_s;
      if (presc_d >= DEAD_CNT) begin
         en_raw_s = onehot_en(idx_d);
      end else begin
         en_raw_s = '0;
      end
      if (digit_act_low_i) begin
         digit_en_d = ~en_raw_s;
      end else begin
         digit_en_d = en_raw_s;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         presc_q       <= '0;
         idx_q         <= 3'd0;
         display_q     <= '0;
         pending_q     <= '0;
         pend_valid_q  <= 1'b0;
         bcd_q         <= 4'h0;
         blank_q       <= 1'b1;
         digit_en_q    <= digit_act_low_i ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
         frame_start_q <= 1'b0;
         load_ack_q    <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         display_q     <= display_d;
         pending_q     <= pending_d;
         pend_valid_q  <= pend_valid_d;
         bcd_q         <= bcd_d;
         blank_q       <= blank_d;
         digit_en_q    <= digit_en_d;
         frame_start_q <= frame_start_d;
         load_ack_q    <= load_ack_d;
      end
   end

   assign bcd_o         = bcd_q;
   assign blank_o       = blank_q;
   assign digit_en_o    = digit_en_q;
   assign digit_idx_o   = idx_q;
   assign frame_start_o = frame_start_q;
   assign load_ack_o    = load_ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed testbench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4,
// DEAD_CYCLES=1. n counts clock edges since the last reset edge, so after
// edge n the prescaler is n%4, the slot is (n/4)%4 and frame boundaries
// fall on multiples of 16.

module tb_seg_scan_ctrl;

   logic        clk;
   logic        rst;
   logic        load;
   logic [15:0] value_in;
   logic        blank_in;
   logic        act_low;
   logic [3:0]  bcd;
   logic        blank;
   logic [3:0]  digit_en;
   logic [2:0]  digit_idx;
   logic        frame_start;
   logic        load_ack;

   int total;
   int bad;
   int n;
   int ack_cnt;
   int fs_cnt;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic LZ = 1'b1;
`else
   localparam logic LZ = 1'b0;
`endif

   seg_scan_ctrl #(
      .NUM_DIGITS (4),
      .DIV_WIDTH  (16),
      .REFRESH_DIV(4),
      .DEAD_CYCLES(1)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .load_i         (load),
      .value_in_i     (value_in),
      .blank_in_i     (blank_in),
      .digit_act_low_i(act_low),
      .bcd_o          (bcd),
      .blank_o        (blank),
      .digit_en_o     (digit_en),
      .digit_idx_o    (digit_idx),
      .frame_start_o  (frame_start),
      .load_ack_o     (load_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s (edge %0d): got %0h want %0h", tag, n, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      n++;
      ack_cnt += int'(load_ack);
      fs_cnt  += int'(frame_start);
   endtask

   task automatic adv_to(input int target);
      while (n < target) tick();
   endtask

   task automatic chk_reset();
      chk("rst_idx",   32'(digit_idx),   32'd0);
      chk("rst_bcd",   32'(bcd),         32'd0);
      chk("rst_blank", 32'(blank),       32'd1);
      chk("rst_en",    32'(digit_en),    32'd0);
      chk("rst_fs",    32'(frame_start), 32'd0);
      chk("rst_ack",   32'(load_ack),    32'd0);
   endtask

   initial begin
      logic [3:0] exp_en;
      total    = 0;
      bad      = 0;
      n        = 0;
      ack_cnt  = 0;
      fs_cnt   = 0;
      rst      = 1'b1;
      load     = 1'b0;
      value_in = 16'h0000;
      blank_in = 1'b0;
      act_low  = 1'b0;

      // Reset state
      tick();
      chk_reset();
      rst    = 1'b0;
      n      = 0;
      fs_cnt = 0;

      // 1: idle scan over one full frame
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp_en = (k % 4 == 0) ? 4'b0000 : 4'(4'b0001 << ((k / 4) % 4));
         chk("scan_idx",   32'(digit_idx),   32'((k / 4) % 4));
         chk("scan_en",    32'(digit_en),    32'(exp_en));
         chk("scan_bcd",   32'(bcd),         32'd0);
         chk("scan_blank", 32'(blank),       32'(LZ && ((k / 4) % 4 != 0)));
         chk("scan_fs",    32'(frame_start), 32'(k == 16));
      end
      chk("scan_fs_count", 32'(fs_cnt), 32'd1);

      // 2: mid-frame load waits for the boundary
      adv_to(18);
      load = 1'b1; value_in = 16'h1234;
      tick();
      load = 1'b0;
      chk("mid_ack_early", 32'(load_ack), 32'd0);
      chk("mid_bcd_old",   32'(bcd),      32'd0);
      ack_cnt = 0;
      adv_to(31);
      chk("mid_no_ack", 32'(ack_cnt), 32'd0);
      tick();
      chk("mid_ack",    32'(load_ack),    32'd1);
      chk("mid_fs",     32'(frame_start), 32'd1);
      chk("mid_bcd0",   32'(bcd),         32'h4);
      chk("mid_blank0", 32'(blank),       32'd0);
      tick();
      chk("mid_ack_pulse", 32'(load_ack), 32'd0);
      adv_to(36);
      chk("mid_bcd1", 32'(bcd), 32'h3);
      adv_to(40);
      chk("mid_bcd2", 32'(bcd), 32'h2);
      adv_to(44);
      chk("mid_bcd3", 32'(bcd),       32'h1);
      chk("mid_idx3", 32'(digit_idx), 32'd3);

      // 3: two loads in one frame, last write wins
      ack_cnt = 0;
      load = 1'b1; value_in = 16'h1111;
      tick();
      load = 1'b0;
      tick();
      load = 1'b1; value_in = 16'h2222;
      tick();
      load = 1'b0;
      chk("two_bcd_old", 32'(bcd), 32'h1);
      tick();
      chk("two_ack",  32'(load_ack), 32'd1);
      chk("two_bcd0", 32'(bcd),      32'h2);
      adv_to(56);
      chk("two_bcd2", 32'(bcd), 32'h2);
      adv_to(61);
      chk("two_ack_count", 32'(ack_cnt), 32'd1);

      // 4: load on the boundary tick supersedes an older pending value
      ack_cnt = 0;
      load = 1'b1; value_in = 16'h9999;
      tick();
      load = 1'b0;
      tick();
      load = 1'b1; value_in = 16'h0005;
      tick();
      load = 1'b0;
      chk("bnd_ack",    32'(load_ack),    32'd1);
      chk("bnd_fs",     32'(frame_start), 32'd1);
      chk("bnd_bcd0",   32'(bcd),         32'h5);
      chk("bnd_blank0", 32'(blank),       32'd0);
      tick();
      chk("bnd_ack_pulse", 32'(load_ack), 32'd0);
      adv_to(68);
      chk("bnd_bcd1",   32'(bcd),   32'h0);
      chk("bnd_blank1", 32'(blank), 32'(LZ));
      adv_to(72);
      chk("bnd_blank2", 32'(blank), 32'(LZ));
      adv_to(76);
      chk("bnd_blank3", 32'(blank), 32'(LZ));
      adv_to(79);

      // 5: active-low digit enables and blank_in latency
      act_low = 1'b1;
      tick();
      chk("bnd_ack_count", 32'(ack_cnt),  32'd1);
      chk("al_dead",       32'(digit_en), 32'hF);
      chk("al_bcd",        32'(bcd),      32'h5);
      blank_in = 1'b1;
      tick();
      chk("al_slot0",  32'(digit_en), 32'hE);
      chk("blank_in1", 32'(blank),    32'd1);
      blank_in = 1'b0;
      tick();
      chk("blank_in0", 32'(blank), 32'd0);
      adv_to(84);
      chk("al_dead1", 32'(digit_en), 32'hF);
      tick();
      chk("al_slot1", 32'(digit_en), 32'hD);
      act_low = 1'b0;
      tick();
      chk("ah_slot1", 32'(digit_en), 32'h2);

      // 6: reset in slot 2 drops a pending load
      adv_to(89);
      chk("pre_rst_idx", 32'(digit_idx), 32'd2);
      load = 1'b1; value_in = 16'h7777;
      tick();
      load = 1'b0;
      rst  = 1'b1;
      tick();
      rst  = 1'b0;
      chk_reset();
      n       = 0;
      ack_cnt = 0;
      fs_cnt  = 0;
      adv_to(16);
      chk("post_rst_fs",  32'(frame_start), 32'd1);
      chk("post_rst_bcd", 32'(bcd),         32'h0);
      adv_to(20);
      chk("post_rst_no_ack", 32'(ack_cnt), 32'd0);
      chk("post_rst_fs_cnt", 32'(fs_cnt),  32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
